smallseg_g0table_writer: RTL

Update-side writer for one small-segment G0 rule table: accepts insert (and optionally delete) requests, encodes rules into the 171-bit G0 entry format, allocates slots and splices them into linked chains. It drives the write/read port of the table RAM whose other port feeds the per-table search pipeline. Each accepted request is answered with exactly one one-cycle response.

---
 rtl/smallseg_g0table_writer.sv | 316 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/smallseg_g0table_writer.sv
// Update-side writer for one small-segment G0 rule table: encodes rules, allocates slots
// and splices them into linked chains. Optional delete-after path: SMALLSEG_G0_DELETE_EN.
module smallseg_g0table_writer #(
    parameter int SUBSET_NUM       = 0,
    parameter int TABLE_NUM        = 0,
    parameter int TABLE_ENTRY_SIZE = 1738,
    parameter int FREE_DEPTH       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_op,
    input  logic [10:0]  req_prev_index,
    input  logic [31:0]  req_srcIP,
    input  logic [31:0]  req_dstIP,
    input  logic [5:0]   req_srcLen,
    input  logic [5:0]   req_dstLen,
    input  logic [15:0]  req_srcPort_lo,
    input  logic [15:0]  req_srcPort_hi,
    input  logic [15:0]  req_dstPort_lo,
    input  logic [15:0]  req_dstPort_hi,
    input  logic [7:0]   req_proto,
    input  logic         req_proto_wild,
    input  logic [10:0]  req_ruleID,
    output logic [10:0]  mem_addr,
    output logic [170:0] mem_din,
    output logic         mem_we,
    input  logic [170:0] mem_dout,
    output logic         resp_valid,
    output logic [1:0]   resp_status,
    output logic [10:0]  resp_index,
    output logic [10:0]  used_count
);

    localparam logic [10:0] NULL_IDX = 11'h7FF;
    localparam logic [10:0] TES_IDX  = 11'(TABLE_ENTRY_SIZE);
    localparam logic [1:0]  ST_OK    = 2'b00;
    localparam logic [1:0]  ST_FULL  = 2'b01;
    localparam logic [1:0]  ST_BAD   = 2'b10;
    localparam logic [1:0]  ST_NF    = 2'b11;

    // Index 2047 is the NULL link, so the table can hold at most 2047 slots.
    if (TABLE_ENTRY_SIZE < 1 || TABLE_ENTRY_SIZE > 2047 || FREE_DEPTH < 1 ||
        SUBSET_NUM < 0 || TABLE_NUM < 0) begin : g_bad_cfg
        $error("smallseg_g0table_writer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WT, S_RD2, S_WT2, S_WR_NEW, S_WR_PREV, S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [10:0]   mem_addr_q, mem_addr_d;
    logic [170:0]  mem_din_q, mem_din_d;
    logic          mem_we_q, mem_we_d;
    logic          resp_valid_q, resp_valid_d;
    logic [1:0]    resp_status_q, resp_status_d;
    logic [10:0]   resp_index_q, resp_index_d;
    logic [10:0]   used_q, used_d;
    logic [10:0]   bump_q, bump_d;
    logic [10:0]   slot_q, slot_d;
    logic [10:0]   prev_q, prev_d;
    logic          op_q, op_d;
    logic [159:0]  entry_q, entry_d;
    logic [159:0]  prev_lo_q, prev_lo_d;

    logic [159:0]  req_body;
    logic          slot_avail;
    logic          prev_bad;
    logic [10:0]   alloc_slot;

`ifdef SMALLSEG_G0_DELETE_EN
    localparam int FIW = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;
    localparam int FCW = $clog2(FREE_DEPTH + 1);
    logic [FCW-1:0] free_cnt_q, free_cnt_d;
    logic [10:0]    tgt_q, tgt_d;
    logic           push_en;
    logic [10:0]    free_mem [2**FIW];
`endif

    // Everything but the next link; the link is spliced in when the word is written.
    always_comb begin
        req_body           = '0;
        req_body[31:0]     = req_srcIP;
        req_body[37:32]    = req_srcLen;
        req_body[69:38]    = req_dstIP;
        req_body[75:70]    = req_dstLen;
        req_body[91:76]    = req_srcPort_hi;
        req_body[107:92]   = req_srcPort_lo;
        req_body[123:108]  = req_dstPort_hi;
        req_body[139:124]  = req_dstPort_lo;
        req_body[147:140]  = req_proto;
        req_body[148]      = req_proto_wild;
        req_body[159:149]  = req_ruleID;
    end

    assign prev_bad = (req_prev_index != NULL_IDX) && (req_prev_index >= TES_IDX);

`ifdef SMALLSEG_G0_DELETE_EN
    assign slot_avail = (free_cnt_q != '0) || (bump_q != TES_IDX);
    assign alloc_slot = (free_cnt_q != '0) ? free_mem[FIW'(free_cnt_q - 1'b1)] : bump_q;
`else
    assign slot_avail = (bump_q != TES_IDX);
    assign alloc_slot = bump_q;
`endif

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        mem_we_d      = 1'b0;
        resp_valid_d  = 1'b0;
        resp_status_d = resp_status_q;
        resp_index_d  = resp_index_q;
        used_d        = used_q;
        bump_d        = bump_q;
        slot_d        = slot_q;
        prev_d        = prev_q;
        op_d          = op_q;
        entry_d       = entry_q;
        prev_lo_d     = prev_lo_q;
`ifdef SMALLSEG_G0_DELETE_EN
        free_cnt_d    = free_cnt_q;
        tgt_d         = tgt_q;
        push_en       = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    prev_d  = req_prev_index;
                    op_d    = req_op;
                    entry_d = req_body;
                    if (req_op == 1'b0) begin
                        if (!slot_avail) begin
                            state_d       = S_RESP;
                            resp_valid_d  = 1'b1;
                            resp_status_d = ST_FULL;
                            resp_index_d  = NULL_IDX;
                        end else if (prev_bad) begin
                            state_d       = S_RESP;
                            resp_valid_d  = 1'b1;
                            resp_status_d = ST_BAD;
                            resp_index_d  = NULL_IDX;
                        end else begin
                            slot_d = alloc_slot;
`ifdef SMALLSEG_G0_DELETE_EN
                            if (free_cnt_q != '0) free_cnt_d = free_cnt_q - 1'b1;
                            else                  bump_d     = bump_q + 11'd1;
`else
                            bump_d = bump_q + 11'd1;
`endif
                            if (req_prev_index == NULL_IDX) begin
                                state_d    = S_WR_NEW;
                                mem_we_d   = 1'b1;
                                mem_addr_d = alloc_slot;
                                mem_din_d  = {NULL_IDX, req_body};
                            end else begin
                                state_d    = S_RD;
                                mem_addr_d = req_prev_index;
                            end
                        end
                    end else begin
`ifdef SMALLSEG_G0_DELETE_EN
                        // Deleting a chain head is not expressible as delete-after.
                        if (req_prev_index == NULL_IDX || prev_bad) begin
                            state_d       = S_RESP;
                            resp_valid_d  = 1'b1;
                            resp_status_d = ST_BAD;
                            resp_index_d  = NULL_IDX;
                        end else begin
                            state_d    = S_RD;
                            mem_addr_d = req_prev_index;
                        end
`else
                        state_d       = S_RESP;
                        resp_valid_d  = 1'b1;
                        resp_status_d = ST_BAD;
                        resp_index_d  = NULL_IDX;
`endif
                    end
                end
            end
            S_RD: state_d = S_WT;
            S_WT: begin
                prev_lo_d = mem_dout[159:0];
                if (op_q == 1'b0) begin
                    state_d    = S_WR_NEW;
                    mem_we_d   = 1'b1;
                    mem_addr_d = slot_q;
                    mem_din_d  = {mem_dout[170:160], entry_q};
                end
`ifdef SMALLSEG_G0_DELETE_EN
                else if (mem_dout[170:160] == NULL_IDX) begin
                    state_d       = S_RESP;
                    resp_valid_d  = 1'b1;
                    resp_status_d = ST_NF;
                    resp_index_d  = NULL_IDX;
                end else begin
                    tgt_d      = mem_dout[170:160];
                    state_d    = S_RD2;
                    mem_addr_d = mem_dout[170:160];
                end
`endif
            end
            S_RD2: state_d = S_WT2;
            S_WT2: begin
                // Predecessor bypasses the target: prev.next = target.next.
                state_d    = S_WR_PREV;
                mem_we_d   = 1'b1;
                mem_addr_d = prev_q;
                mem_din_d  = {mem_dout[170:160], prev_lo_q};
            end
            S_WR_NEW: begin
                if (op_q == 1'b0) begin
                    if (prev_q == NULL_IDX) begin
                        state_d       = S_RESP;
                        resp_valid_d  = 1'b1;
                        resp_status_d = ST_OK;
                        resp_index_d  = slot_q;
                        used_d        = used_q + 11'd1;
                    end else begin
                        state_d    = S_WR_PREV;
                        mem_we_d   = 1'b1;
                        mem_addr_d = prev_q;
                        mem_din_d  = {slot_q, prev_lo_q};
                    end
                end else begin
                    // Delete spends this cycle recycling the unlinked slot.
                    state_d       = S_RESP;
                    resp_valid_d  = 1'b1;
                    resp_status_d = ST_OK;
                    used_d        = used_q - 11'd1;
`ifdef SMALLSEG_G0_DELETE_EN
                    resp_index_d  = tgt_q;
                    if (free_cnt_q != FCW'(FREE_DEPTH)) begin
                        push_en    = 1'b1;
                        free_cnt_d = free_cnt_q + 1'b1;
                    end
`endif
                end
            end
            S_WR_PREV: begin
                if (op_q == 1'b0) begin
                    state_d       = S_RESP;
                    resp_valid_d  = 1'b1;
                    resp_status_d = ST_OK;
                    resp_index_d  = slot_q;
                    used_d        = used_q + 11'd1;
                end else begin
                    state_d = S_WR_NEW;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_we_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_status_q <= ST_OK;
            resp_index_q  <= '0;
            used_q        <= '0;
            bump_q        <= '0;
            slot_q        <= '0;
            prev_q        <= '0;
            op_q          <= 1'b0;
            entry_q       <= '0;
            prev_lo_q     <= '0;
`ifdef SMALLSEG_G0_DELETE_EN
            free_cnt_q    <= '0;
            tgt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_we_q      <= mem_we_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            resp_index_q  <= resp_index_d;
            used_q        <= used_d;
            bump_q        <= bump_d;
            slot_q        <= slot_d;
            prev_q        <= prev_d;
            op_q          <= op_d;
            entry_q       <= entry_d;
            prev_lo_q     <= prev_lo_d;
`ifdef SMALLSEG_G0_DELETE_EN
            free_cnt_q    <= free_cnt_d;
            tgt_q         <= tgt_d;
`endif
        end
    end

`ifdef SMALLSEG_G0_DELETE_EN
    always_ff @(posedge clk) begin
        if (push_en) free_mem[FIW'(free_cnt_q)] <= tgt_q;
    end
`endif

    assign req_ready   = (state_q == S_IDLE);
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_we      = mem_we_q;
    assign resp_valid  = resp_valid_q;
    assign resp_status = resp_status_q;
    assign resp_index  = resp_index_q;
    assign used_count  = used_q;

endmodule
